pop_uart_tx: RTL and testbench

Serial transmitter that dumps one 150-bit path of the genetic-algorithm population over the board UART pin. It sits at the far end of the State module's `uart_transmit` strobe: State pulses `start` with the path to report, and this block frames it as 8N1 bytes on `uart_out`. It raises `done` when the last stop bit has gone out.

---
 rtl/pop_uart_tx_pkg.sv | 17 +
 rtl/uart_tx_byte.sv | 116 +++++++++++
 rtl/pop_uart_tx.sv | 81 ++++++++
 tb/tb_pop_uart_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pop_uart_tx_pkg.sv
// Shared constants and state encoding for the population-dump UART link.
// A future receiver imports the same package so framing stays consistent.
package pop_uart_tx_pkg;

  localparam int         UART_CLKS_PER_BIT = 868;
  localparam int         POP_PATH_W        = 150;
  localparam logic [7:0] UART_SYNC_BYTE    = 8'hA5;
  localparam int         POP_NBYTES        = (POP_PATH_W + 7) / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA,
    ST_STOP_BIT
  } uart_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 single-byte serializer. Ready rises in IDLE and in the last cycle of a
// stop bit, so a waiting byte follows the previous one with no idle gap.
module uart_tx_byte
  import pop_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  uart_state_e       r_state;
  uart_state_e       w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_nxt;
  logic [7:0]        r_data;
  logic [7:0]        w_data_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign o_ready   = (r_state == ST_IDLE) || ((r_state == ST_STOP_BIT) && w_bit_end);
  assign o_tx      = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_data <= w_data_nxt;
  end

  // Data shifts right each bit period so the next bit to send is always r_data[0/1].
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_data_nxt    = r_data;
    w_tx_nxt      = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (i_valid) begin
          w_state_nxt = ST_START_BIT;
          w_baud_nxt  = '0;
          w_data_nxt  = i_data;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START_BIT: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_data[0];
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP_BIT;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_data_nxt    = r_data >> 1;
            w_tx_nxt      = r_data[1];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      ST_STOP_BIT: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (i_valid) begin
            w_state_nxt = ST_START_BIT;
            w_data_nxt  = i_data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pop_uart_tx.sv
// Frames one population path as a sync byte plus ceil(PATH_W/8) payload bytes,
// LSB byte first, over an 8N1 UART line; pulses done after the last stop bit.
module pop_uart_tx
  import pop_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int         PATH_W       = POP_PATH_W,
  parameter logic [7:0] SYNC_BYTE    = UART_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PATH_W-1:0] path,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES  = (PATH_W + 7) / 8;
  localparam int SHIFT_W = NBYTES * 8;

  logic               r_busy;
  logic               r_done;
  logic [4:0]         r_byte_idx;
  logic [SHIFT_W-1:0] r_shift;
  logic               w_accept;
  logic               w_last;
  logic               w_next;
  logic               w_ready;
  logic               w_valid;
  logic [7:0]         w_data;

  // Byte index counts the byte on the line: 0 is the header, NBYTES the last payload byte.
  assign w_accept = start && !r_busy;
  assign w_last   = (r_byte_idx == 5'(NBYTES));
  assign w_next   = r_busy && w_ready && !w_last;
  assign w_valid  = w_accept || w_next;
  assign w_data   = r_busy ? r_shift[7:0] : SYNC_BYTE;

  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_byte_idx <= '0;
      end else if (w_next) begin
        r_byte_idx <= r_byte_idx + 5'd1;
      end else if (r_busy && w_ready) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= SHIFT_W'(path);
    end else if (w_next) begin
      r_shift <= r_shift >> 8;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_valid),
    .i_data (w_data),
    .o_ready(w_ready),
    .o_tx   (tx)
  );

endmodule

// File: tb/tb_pop_uart_tx.sv
// Bench for pop_uart_tx: frames are predicted from the byte list of each path
// and compared against tx, busy and done every cycle.
module tb_pop_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 200 * C;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [149:0] path;
  logic         tx;
  logic         busy;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pop_uart_tx #(
    .CLKS_PER_BIT(C),
    .PATH_W      (150),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .path (path),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [149:0] p, input int k);
    logic [151:0] padded;
    padded = {2'b00, p};
    if (k == 0) return 8'hA5;
    return padded[8*(k-1) +: 8];
  endfunction

  function automatic logic model_tx(input logic [149:0] p, input int cyc);
    int         b;
    int         pos;
    logic [7:0] byt;
    b   = cyc / C;
    pos = b % 10;
    byt = model_byte(p, b / 10);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byt[pos-1];
  endfunction

  function automatic logic [149:0] rand150();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[149:0];
  endfunction

  // Called at a negedge; the following posedge samples start.
  task automatic run_frame(input logic [149:0] p, input int inject_cyc,
                           input int abort_cyc, input bit chain);
    int         run;
    int         b;
    int         pos;
    logic       prev;
    logic [7:0] dec;
    path  = p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    path  = rand150();
    prev  = 1'b1;
    run   = 0;
    dec   = 8'h00;
    for (int cyc = 0; cyc < FRAME; cyc++) begin
      check("tx", tx, model_tx(p, cyc));
      check("busy", busy, 1);
      check("done_early", done, 0);
      if (tx !== prev) begin
        if (cyc != 0) check("run_len", ((run % C) == 0) && (run >= C), 1);
        run = 1;
      end else begin
        run++;
      end
      prev = tx;
      if ((cyc % C) == C / 2) begin
        b   = cyc / C;
        pos = b % 10;
        if (pos >= 1 && pos <= 8) dec[pos-1] = tx;
        if (pos == 9) check("byte", dec, model_byte(p, b / 10));
      end
      if (cyc == abort_cyc) begin
        rst = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (4) begin
          @(negedge clk);
          check("abort_hold_done", done, 0);
          check("abort_hold_tx", tx, 1);
        end
        rst = 1'b0;
        return;
      end
      start = (cyc == inject_cyc);
      if (cyc == inject_cyc) path = rand150();
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("tx_end", tx, 1);
    if (!chain) begin
      @(negedge clk);
      check("done_width", done, 0);
      check("tx_idle", tx, 1);
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    logic [149:0] pat;
    rst   = 1'b0;
    start = 1'b0;
    path  = '0;

    #2 rst = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (10) begin
      @(negedge clk);
      check("rst_hold_tx", tx, 1);
    end
    rst = 1'b0;
    @(negedge clk);

    run_frame(150'h1, -1, -1, 1'b0);
    run_frame({150{1'b1}}, -1, -1, 1'b0);

    run_frame(rand150(), 100, -1, 1'b1);
    run_frame(rand150(), -1, -1, 1'b0);

    run_frame(rand150(), -1, (5 * 10 + 1 + 3) * C + 1, 1'b0);
    run_frame(150'h2, -1, -1, 1'b0);

    pat = '0;
    for (int k = 0; k < 19; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (8 * k + i < 150) pat[8*k+i] = ((k % 2) == 0) ? (i % 2 == 0) : (i % 2 == 1);
      end
    end
    run_frame(pat, -1, -1, 1'b0);

    repeat (2) run_frame(rand150(), -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
